multdiv_seq: RTL and testbench
==============================

Name: multdiv_seq

Overview:
Multicycle sequencer for the MULT/DIV instructions. It owns the iteration counter and the shift/add and restore datapath, and produces 64-bit results for the HI/LO registers. It is launched by the main Control FSM with operands taken from regA/regB. Control holds in its wait state until Done, then continues the instruction. It also reports divide-by-zero to the exception path.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low; all state cleared while low
Start  in  1  launch request; sampled only in IDLE
Op  in  1  0 = MULT (signed), 1 = DIV (signed)
A  in  WIDTH  multiplicand / dividend (regA output)
B  in  WIDTH  multiplier / divisor (regB output)
Busy  out  1  high from LOAD through DONE inclusive
Done  out  1  one-cycle pulse; result valid
DivZero  out  1  one-cycle pulse; DIV with B == 0
HiOut  out  WIDTH  upper product / remainder; feeds the HI register input mux
LoOut  out  WIDTH  lower product / quotient; feeds the LO register input mux
HiWrite  out  1  load strobe for HI, equal to Done
LoWrite  out  1  load strobe for LO, equal to Done

Behaviour:
- Reset (Reset low, asynchronous):
  - state = IDLE; counter = 0.
  - Busy, Done, DivZero, HiWrite, LoWrite = 0.
  - HiOut and LoOut = 0.
  - Reset mid-operation aborts the operation immediately; no write strobe is produced.
- States: IDLE, LOAD, RUN, FIXUP, DONE.
- IDLE:
  - Start = 1 moves to LOAD.
  - A, B and Op are captured on that edge (edge k).
- LOAD (cycle k+1):
  - Divide-by-zero case (Op = DIV, B == 0): pulse DivZero for this cycle and return to IDLE. HiWrite/LoWrite stay low and HiOut/LoOut keep their previous values.
  - MULT: initialise the Booth radix-2 accumulator, with product = {0, B, 0}.
  - DIV: take absolute values, and record sign_q = A[W-1]^B[W-1] and sign_r = A[W-1].
  - Counter loads WIDTH; go to RUN.
- RUN (cycles k+2 .. k+WIDTH+1):
  - One step per cycle, counter decrements; counter reaching 0 goes to FIXUP.
  - MULT step: inspect the pair {p[0], p[-1]}; add or subtract A into the upper half; arithmetic shift right by 1.
  - DIV step (restoring): shift {R,Q} left; trial R - |B|; if non-negative, keep it and set Q[0] = 1.
- FIXUP (cycle k+WIDTH+2):
  - DIV only: negate Q if sign_q; negate R if sign_r.
  - MULT: no operation, so both ops have uniform latency.
- DONE (cycle k+WIDTH+3):
  - Drive HiOut/LoOut registered; Done = HiWrite = LoWrite = 1 for exactly this cycle; then IDLE.
- Total latency is WIDTH+3 cycles from the Start edge to the Done cycle (35 for WIDTH = 32).
- Result semantics:
  - MULT: full signed 2W-bit product, with HI = [2W-1:W] and LO = [W-1:0].
  - DIV: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - 0x80000000 / -1 wraps: LO = 0x80000000, HI = 0; no flag.
- Start while Busy is ignored, with no queuing.
- Start in the same cycle as Done is ignored; it is accepted from the following IDLE cycle.
- HiOut/LoOut hold their last values between operations.

Optional Feature:
MULTDIV_UNSIGNED_EN
- Defined:
  - Adds input port Uns (1 bit), captured with Op; Uns = 1 selects MULTU/DIVU.
  - MULTU uses a 1-bit zero-extended Booth accumulator.
  - DIVU skips the absolute-value step and FIXUP negation.
  - Latency is unchanged.
- Undefined: the port is absent and every operation is signed.

Decomposition:
- Shared package multdiv_pkg contains:
  - typedef md_op_t {MD_MULT, MD_DIV}
  - typedef md_state_t {IDLE, LOAD, RUN, FIXUP, DONE}
  - constant MD_WIDTH = 32
- One natural sub-module: div_restore_step, a combinational single-iteration restore (inputs R, Q, |B|; outputs R', Q').
- The Booth step stays inline.

Test Plan:
1. MULT A = 7, B = -3 (0xFFFFFFFD) -> Done at cycle 35; HiOut = 0xFFFFFFFF, LoOut = 0xFFFFFFEB; HiWrite = LoWrite = 1 for one cycle.
2. MULT A = B = 0x7FFFFFFF -> HiOut = 0x3FFFFFFF, LoOut = 0x00000001.
3. DIV A = -7, B = 2 -> LoOut = 0xFFFFFFFD, HiOut = 0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> LoOut = 0x80000000, HiOut = 0.
4. DIV A = 5, B = 0 -> DivZero pulse at cycle 1; no Done and no write strobes; HiOut/LoOut unchanged; Busy low from cycle 2.
5. Start MULT, pulse Start again at cycle 10, then assert Reset low at cycle 20:
   - The second Start is ignored.
   - After reset, all outputs = 0 and the state is IDLE.
   - A new MULT 3×4 gives LoOut = 12 at cycle 35 after its Start.
6. With MULTDIV_UNSIGNED_EN: MULTU 0xFFFFFFFF × 2 -> HiOut = 1, LoOut = 0xFFFFFFFE; DIVU 0xFFFFFFFF / 2 -> LoOut = 0x7FFFFFFF, HiOut = 1.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared operation/state types and default operand width for the MULT/DIV sequencer.
package multdiv_pkg;
    localparam int MD_WIDTH = 32;

    typedef enum logic {
        MD_MULT = 1'b0,
        MD_DIV  = 1'b1
    } md_op_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIXUP,
        DONE
    } md_state_t;
endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the divisor magnitude.
module div_restore_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;

    // The shifted remainder needs one extra bit when the divisor uses the full width.
    assign shifted = {remIn, quoIn[WIDTH-1]};
    assign fits    = shifted >= {1'b0, divisor};
    assign trial   = shifted[WIDTH-1:0] - divisor;
    assign remOut  = fits ? trial : shifted[WIDTH-1:0];
    assign quoOut  = {quoIn[WIDTH-2:0], fits};
endmodule

// File: rtl/multdiv_seq.sv
// Multicycle MULT/DIV sequencer producing HI/LO results with a fixed WIDTH+3 cycle latency.
// Optional MULTDIV_UNSIGNED_EN adds the Uns input selecting MULTU/DIVU.
//
// state | meaning
// IDLE  | waiting for Start; operands captured on the accepting edge
// LOAD  | divide-by-zero check, accumulator/abs-value setup
// RUN   | one Booth or restoring step per cycle, WIDTH cycles
// FIXUP | sign correction for DIV, unsigned correction for MULTU, result registers load
// DONE  | result valid, HI/LO write strobes
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Op,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             Uns,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             HiWrite,
    output logic             LoWrite
);
    localparam int CW = $clog2(WIDTH + 1);

    md_state_t        state, stateNext;
    md_op_t           opQ;
    logic [WIDTH-1:0] opA, opB;
    logic [WIDTH:0]   accHi;
    logic [WIDTH-1:0] accLo;
    logic             boothBit;
    logic [CW-1:0]    count;
    logic             signQ, signR;
    logic             uns;
    logic             divByZero;
    logic [WIDTH:0]   aExt, boothSum;
    logic [WIDTH-1:0] remNext, quoNext;

`ifdef MULTDIV_UNSIGNED_EN
    logic unsQ;
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            unsQ <= 1'b0;
        else if (state == IDLE && Start)
            unsQ <= Uns;
    end
    assign uns = unsQ;
`else
    assign uns = 1'b0;
`endif

    assign divByZero = (opQ == MD_DIV) && (opB == '0);
    assign aExt      = {opA[WIDTH-1] & ~uns, opA};

    always_comb begin
        boothSum = accHi;
        case ({accLo[0], boothBit})
            2'b01:   boothSum = accHi + aExt;
            2'b10:   boothSum = accHi - aExt;
            default: boothSum = accHi;
        endcase
    end

    div_restore_step #(.WIDTH(WIDTH)) uStep (
        .remIn  (accHi[WIDTH-1:0]),
        .quoIn  (accLo),
        .divisor(opB),
        .remOut (remNext),
        .quoOut (quoNext)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        Busy      = (state != IDLE);
        Done      = 1'b0;
        DivZero   = 1'b0;
        case (state)
            IDLE:  if (Start) stateNext = LOAD;
            LOAD: begin
                if (divByZero) begin
                    DivZero   = 1'b1;
                    stateNext = IDLE;
                end else begin
                    stateNext = RUN;
                end
            end
            RUN:   if (count == CW'(1)) stateNext = FIXUP;
            FIXUP: stateNext = DONE;
            DONE: begin
                Done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign HiWrite = Done;
    assign LoWrite = Done;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            opQ      <= MD_MULT;
            opA      <= '0;
            opB      <= '0;
            accHi    <= '0;
            accLo    <= '0;
            boothBit <= 1'b0;
            count    <= '0;
            signQ    <= 1'b0;
            signR    <= 1'b0;
            HiOut    <= '0;
            LoOut    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        opQ <= md_op_t'(Op);
                        opA <= A;
                        opB <= B;
                    end
                end
                LOAD: begin
                    count    <= CW'(WIDTH);
                    accHi    <= '0;
                    boothBit <= 1'b0;
                    if (opQ == MD_MULT) begin
                        accLo <= opB;
                        signQ <= 1'b0;
                        signR <= 1'b0;
                    end else begin
                        // opB is reused as the divisor magnitude from here on
                        accLo <= (!uns && opA[WIDTH-1]) ? -opA : opA;
                        opB   <= (!uns && opB[WIDTH-1]) ? -opB : opB;
                        signQ <= !uns && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                        signR <= !uns && opA[WIDTH-1];
                    end
                end
                RUN: begin
                    count <= count - CW'(1);
                    if (opQ == MD_MULT) begin
                        {accHi, accLo, boothBit} <= {boothSum[WIDTH], boothSum, accLo};
                    end else begin
                        accHi <= {1'b0, remNext};
                        accLo <= quoNext;
                    end
                end
                FIXUP: begin
                    if (opQ == MD_MULT) begin
                        // Booth treats B as signed; an unsigned B with its top bit set owes A<<WIDTH
                        HiOut <= accHi[WIDTH-1:0] + ((uns && opB[WIDTH-1]) ? opA : '0);
                        LoOut <= accLo;
                    end else begin
                        HiOut <= signR ? -accHi[WIDTH-1:0] : accHi[WIDTH-1:0];
                        LoOut <= signQ ? -accLo : accLo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: driver pushes reference results, negedge monitor pops and compares.
module tb_multdiv_seq;
    localparam int W   = 32;
    localparam int LAT = W + 3;

    typedef logic [63:0] u64;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Start = 1'b0;
    logic         Op = 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
    logic         Uns = 1'b0;
`endif
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Busy, Done, DivZero, HiWrite, LoWrite;
    logic [W-1:0] HiOut, LoOut;

    typedef struct {
        bit           dz;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           k;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           fails = 0;
    int           cycleCnt = 0;
    logic [W-1:0] lastHi = '0;
    logic [W-1:0] lastLo = '0;
    logic [W-1:0] corners [8] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                                  32'h7FFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h3};

    multdiv_seq #(.WIDTH(W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Op     (Op),
`ifdef MULTDIV_UNSIGNED_EN
        .Uns    (Uns),
`endif
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .Done   (Done),
        .DivZero(DivZero),
        .HiOut  (HiOut),
        .LoOut  (LoOut),
        .HiWrite(HiWrite),
        .LoWrite(LoWrite)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cycleCnt++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero with dividend-signed remainder.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                                  input logic u, output bit dz, output logic [W-1:0] hi,
                                  output logic [W-1:0] lo);
        longint sq, sr;
        u64     up;
        dz = op && (b == '0);
        hi = lastHi;
        lo = lastLo;
        if (dz) return;
        if (!op) begin
            if (u) up = u64'(a) * u64'(b);
            else   up = u64'(longint'($signed(a)) * longint'($signed(b)));
            hi = up[63:32];
            lo = up[31:0];
        end else if (u) begin
            lo = a / b;
            hi = a % b;
        end else begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            lo = sq[31:0];
            hi = sr[31:0];
        end
    endfunction

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic u,
                        input int k, output bit dz);
        exp_t         e;
        logic [W-1:0] h, l;
        model(a, b, op, u, dz, h, l);
        e.dz = dz;
        e.hi = h;
        e.lo = l;
        e.k  = k;
        sb.push_back(e);
        if (!dz) begin
            lastHi = h;
            lastLo = l;
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic u,
                         output int k, output bit dz);
        @(negedge Clk);
        A = a;
        B = b;
        Op = op;
`ifdef MULTDIV_UNSIGNED_EN
        Uns = u;
`endif
        Start = 1'b1;
        @(posedge Clk);
        #1;
        k = cycleCnt;
        push(a, b, op, u, k, dz);
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic checkCleared();
        chk("resetCtl", {Busy, Done, DivZero, HiWrite, LoWrite}, 5'b0);
        chk("resetHi", HiOut, 0);
        chk("resetLo", LoOut, 0);
    endtask

    task automatic applyReset();
        Start = 1'b0;
        Reset = 1'b0;
        sb.delete();
        lastHi = '0;
        lastLo = '0;
        #1;
        checkCleared();
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
    endtask

    // Waits for Busy to fall; optionally re-pulses Start or asserts reset at a cycle offset from the launch.
    task automatic waitIdle(input int k, input bit dz, input logic op, input int pokeAt, input int resetAt);
        bit idle = 0;
        int off;
        for (int i = 0; i < 100 && !idle; i++) begin
            off = cycleCnt - k;
            if (off == resetAt) begin
                applyReset();
                return;
            end
            Start = (off == pokeAt);
            if (off == pokeAt) begin
                A  = $urandom;
                B  = $urandom;
                Op = ~op;
            end
            if (!Busy) idle = 1;
            else @(negedge Clk);
        end
        Start = 1'b0;
        if (!idle) chk("idleTimeout", 0, 1);
        else       chk("busyDrop", cycleCnt - k, dz ? 1 : LAT);
    endtask

    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic u,
                         input int pokeAt, input int resetAt);
        int k;
        bit dz;
        issue(a, b, op, u, k, dz);
        waitIdle(k, dz, op, pokeAt, resetAt);
    endtask

    // Start held high through the Done cycle must only be taken in the following IDLE cycle.
    task automatic backToBack(input logic [W-1:0] a1, input logic [W-1:0] b1, input logic op1,
                              input logic [W-1:0] a2, input logic [W-1:0] b2, input logic op2);
        int k, d;
        bit dz, dz2;
        bit seen = 0;
        issue(a1, b1, op1, 1'b0, k, dz);
        for (int i = 0; i < 100 && !seen; i++) begin
            if (Done) seen = 1;
            else @(negedge Clk);
        end
        if (!seen) begin
            chk("doneTimeout", 0, 1);
            return;
        end
        d = cycleCnt;
        A = a2;
        B = b2;
        Op = op2;
`ifdef MULTDIV_UNSIGNED_EN
        Uns = 1'b0;
`endif
        Start = 1'b1;
        push(a2, b2, op2, 1'b0, d + 2, dz2);
        repeat (2) @(negedge Clk);
        Start = 1'b0;
        waitIdle(d + 2, dz2, op2, -1, -1);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (Reset && (Done || DivZero || HiWrite || LoWrite)) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpectedResult: Done=%b DivZero=%b HiWrite=%b LoWrite=%b, none pending",
                         Done, DivZero, HiWrite, LoWrite);
            end else begin
                e = sb.pop_front();
                chk("resultKind", {DivZero, Done, HiWrite, LoWrite}, e.dz ? 4'b1000 : 4'b0111);
                chk("latency", cycleCnt - e.k, e.dz ? 0 : LAT - 1);
                chk("hiOut", HiOut, e.hi);
                chk("loOut", LoOut, e.lo);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d pending results", sb.size());
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rop, ru;
        repeat (2) @(negedge Clk);
        checkCleared();
        Reset = 1'b1;

        runOp(32'd7,        32'hFFFFFFFD, 1'b0, 1'b0, -1, -1);
        runOp(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, -1, -1);
        runOp(32'hFFFFFFF9, 32'd2,        1'b1, 1'b0, -1, -1);
        runOp(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, -1, -1);
        runOp(32'd5,        32'd0,        1'b1, 1'b0, -1, -1);
        runOp(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 10, -1);
        runOp(32'h0BADF00D, 32'hFFFF1234, 1'b0, 1'b0, 10, 20);
        runOp(32'd3,        32'd4,        1'b0, 1'b0, -1, -1);
        backToBack(32'hFFFFFF00, 32'd77, 1'b1, 32'h80000000, 32'h80000000, 1'b0);
`ifdef MULTDIV_UNSIGNED_EN
        runOp(32'hFFFFFFFF, 32'd2,        1'b0, 1'b1, -1, -1);
        runOp(32'hFFFFFFFF, 32'd2,        1'b1, 1'b1, -1, -1);
        runOp(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, -1, -1);
`endif
        for (int i = 0; i < 40; i++) begin
            ra  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
            rb  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
            rop = 1'($urandom_range(0, 1));
`ifdef MULTDIV_UNSIGNED_EN
            ru  = 1'($urandom_range(0, 1));
`else
            ru  = 1'b0;
`endif
            runOp(ra, rb, rop, ru, -1, -1);
        end

        repeat (40) @(negedge Clk);
        chk("scoreboardDrained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
